// File: rtl/mult_parity_responder.sv
// mult_parity_responder: parity-checked 16x16 signed multiplier responder with fixed-latency req/ack handshake
module mult_parity_responder #(
  parameter int MULT_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] arg_a,
  input  logic        arg_a_parity,
  input  logic [15:0] arg_b,
  input  logic        arg_b_parity,
  input  logic        req,
  output logic        ack,
  output logic [31:0] result,
  output logic        result_parity,
  output logic        result_rdy,
  output logic        arg_parity_error
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic ap_q, ap_d, bp_q, bp_d;
  logic ack_q, ack_d, rdy_q, rdy_d, rpar_q, rpar_d, perr_q, perr_d;
  logic [31:0] res_q, res_d, prod, res_new;
  logic err, capture;
  assign err = (ap_q != ^a_q) | (bp_q != ^b_q);
  assign prod = $signed({{16{a_q[15]}}, a_q}) * $signed({{16{b_q[15]}}, b_q});
  assign res_new = err ? 32'd0 : prod;
  // DONE returns to IDLE on its closing edge, so that edge may already take the next request
  assign capture = req && (state_q == IDLE || state_q == DONE);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    ap_d = ap_q;
    bp_d = bp_q;
    ack_d = 1'b0;
    rdy_d = 1'b0;
    res_d = res_q;
    rpar_d = rpar_q;
    perr_d = perr_q;
    if (capture) begin
      a_d = arg_a;
      b_d = arg_b;
      ap_d = arg_a_parity;
      bp_d = arg_b_parity;
      ack_d = 1'b1;
      cnt_d = 4'(MULT_LATENCY - 1);
      state_d = BUSY;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      if (cnt_q == 4'd0) begin
        state_d = DONE;
        rdy_d = 1'b1;
        res_d = res_new;
        rpar_d = ^res_new;
        perr_d = err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      ap_q <= 1'b0;
      bp_q <= 1'b0;
      ack_q <= 1'b0;
      rdy_q <= 1'b0;
      res_q <= '0;
      rpar_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      ap_q <= ap_d;
      bp_q <= bp_d;
      ack_q <= ack_d;
      rdy_q <= rdy_d;
      res_q <= res_d;
      rpar_q <= rpar_d;
      perr_q <= perr_d;
    end
  end
  assign ack = ack_q;
  assign result_rdy = rdy_q;
  assign result = res_q;
  assign result_parity = rpar_q;
  assign arg_parity_error = perr_q;
endmodule

// File: tb/tb_mult_parity_responder.sv
// tb_mult_parity_responder: randomized and directed checks of the multiplier responder against an arithmetic model
module tb_mult_parity_responder;
  localparam int L = 3;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, ap = 1'b0, bp = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic ack, result_parity, result_rdy, arg_parity_error;
  logic [31:0] result;
  int checks = 0, errors = 0;
  logic [31:0] last_res = '0;
  logic last_par = 1'b0, last_err = 1'b0;

  mult_parity_responder #(.MULT_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .arg_a(a), .arg_a_parity(ap), .arg_b(b), .arg_b_parity(bp),
    .req(req), .ack(ack), .result(result), .result_parity(result_parity),
    .result_rdy(result_rdy), .arg_parity_error(arg_parity_error)
  );

  always #5 clk = ~clk;

  function automatic logic odd(input logic [31:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic txn(input logic [15:0] ta, input logic tap, input logic [15:0] tb, input logic tbp, input bit busy_pulse);
    logic e;
    logic [31:0] er;
    logic ep;
    e = (tap != odd({16'd0, ta})) || (tbp != odd({16'd0, tb}));
    er = e ? 32'd0 : 32'(int'($signed(ta)) * int'($signed(tb)));
    ep = odd(er);
    a = ta; ap = tap; b = tb; bp = tbp; req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1 || result_rdy !== 1'b0) begin
      errors++;
      $display("FAIL ack_at_capture a=%h b=%h: ack=%b rdy=%b, expected ack=1 rdy=0", ta, tb, ack, result_rdy);
    end
    checks++;
    if ({result, result_parity, arg_parity_error} !== {last_res, last_par, last_err}) begin
      errors++;
      $display("FAIL output_hold: got %h/%b/%b, expected %h/%b/%b", result, result_parity, arg_parity_error, last_res, last_par, last_err);
    end
    req = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ap = 1'($urandom); bp = 1'($urandom);
    for (int k = 1; k <= L; k++) begin
      if (busy_pulse) req = (k == 2);
      @(posedge clk); #1;
      if (k < L) begin
        checks++;
        if (ack !== 1'b0 || result_rdy !== 1'b0) begin
          errors++;
          $display("FAIL busy_quiet cycle %0d: ack=%b rdy=%b, expected 0 0", k, ack, result_rdy);
        end
      end else begin
        checks++;
        if (result_rdy !== 1'b1 || ack !== 1'b0) begin
          errors++;
          $display("FAIL rdy_latency: rdy=%b ack=%b, expected rdy=1 ack=0", result_rdy, ack);
        end
        checks++;
        if (result !== er || result_parity !== ep || arg_parity_error !== e) begin
          errors++;
          $display("FAIL result a=%h/%b b=%h/%b: got %h/%b/%b, expected %h/%b/%b", ta, tap, tb, tbp, result, result_parity, arg_parity_error, er, ep, e);
        end
      end
    end
    req = 1'b0;
    last_res = er; last_par = ep; last_err = e;
  endtask

  task automatic idle_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || result_rdy !== 1'b0 || {result, result_parity, arg_parity_error} !== {last_res, last_par, last_err}) begin
        errors++;
        $display("FAIL %s cycle %0d: ack=%b rdy=%b out=%h/%b/%b, expected 0 0 %h/%b/%b", tag, i, ack, result_rdy, result, result_parity, arg_parity_error, last_res, last_par, last_err);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; a = 16'd3; b = 16'd4;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    checks++;
    if (ack !== 1'b0 || result_rdy !== 1'b0 || result !== 32'd0 || result_parity !== 1'b0 || arg_parity_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ack=%b rdy=%b out=%h/%b/%b, expected all 0", ack, result_rdy, result, result_parity, arg_parity_error);
    end
    last_res = '0; last_par = 1'b0; last_err = 1'b0;
    idle_quiet(10, "reset_idle");
  endtask

  task automatic test_directed();
    txn(16'd3, 1'b0, 16'hFFFB, 1'b1, 0);
    txn(16'd1, 1'b0, 16'd2, 1'b1, 0);
    txn(16'd1, 1'b1, 16'd2, 1'b0, 0);
    txn(16'd1, 1'b0, 16'd2, 1'b0, 0);
    txn(16'h8000, 1'b1, 16'h8000, 1'b1, 0);
    txn(16'h7FFF, 1'b1, 16'h8000, 1'b1, 0);
    checks++;
    if (result !== 32'hC000_8000) begin
      errors++;
      $display("FAIL max_neg_product: got %h, expected c0008000", result);
    end
    idle_quiet(2, "after_directed");
  endtask

  task automatic test_busy_req();
    txn(16'd100, 1'b1, 16'hFF9C, 1'b0, 1);
    idle_quiet(L + 2, "busy_req_no_second");
  endtask

  task automatic test_back_to_back();
    txn(16'd1234, 1'b1, 16'd5678, 1'b0, 0);
    txn(16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 0);
    txn(16'd9, 1'b0, 16'hFFF7, 1'b1, 0);
    idle_quiet(2, "after_b2b");
  endtask

  task automatic test_reset_mid();
    a = 16'd11; ap = 1'b1; b = 16'd13; bp = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ack: ack=%b, expected 1", ack);
    end
    req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ack !== 1'b0 || result_rdy !== 1'b0 || result !== 32'd0 || result_parity !== 1'b0 || arg_parity_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: ack=%b rdy=%b out=%h/%b/%b, expected all 0", ack, result_rdy, result, result_parity, arg_parity_error);
    end
    last_res = '0; last_par = 1'b0; last_err = 1'b0;
    idle_quiet(L + 2, "reset_mid_discard");
    txn(16'd6, 1'b0, 16'd7, 1'b1, 0);
    checks++;
    if (result !== 32'h2A || result_parity !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_6x7: got %h/%b, expected 0000002a/1", result, result_parity);
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 16'h8000;
        1: ra = 16'h7FFF;
        2: ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      txn(ra, odd({16'd0, ra}) ^ ($urandom_range(0, 3) == 0),
          rb, odd({16'd0, rb}) ^ ($urandom_range(0, 3) == 0), 0);
      idle_quiet($urandom_range(0, 2), "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_req();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_parity_responder.md
# mult_parity_responder

Responder end of the multiplier request/acknowledge protocol: accepts two 16-bit signed operands with per-operand parity bits, acknowledges the request, checks operand parity and returns a 32-bit signed product with result parity after a fixed latency. It is the synthesizable DUT that sits behind the team's mult testbench interface. It is driven by the initiator's `req`/`arg_*` signals and answers on `ack`/`result*`.

## Interface
- MULT_LATENCY, 3, cycles from capture edge to `result_rdy` assertion; legal range 2..15
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- arg_a  in  16  operand A, signed two's complement
- arg_a_parity  in  1  parity for A; valid when equal to XOR-reduction of `arg_a`
- arg_b  in  16  operand B, signed
- arg_b_parity  in  1  parity for B; same rule as A
- req  in  1  request; initiator holds high until it sees `ack`
- ack  out  1  one-cycle acceptance pulse
- result  out  32  signed product, or 0 on parity error
- result_parity  out  1  XOR-reduction of `result`
- result_rdy  out  1  one-cycle result-valid pulse
- arg_parity_error  out  1  set when either operand parity was invalid for the current result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: on an edge with `req`=1, capture `arg_a`, `arg_b` and both parity bits.
  - Assert `ack` for the following cycle.
  - Load the latency counter with MULT_LATENCY-1.
  - Go to BUSY.
- BUSY: decrement the counter each edge.
  - When the counter is 0, register the outputs and go to DONE.
  - `req` is ignored in BUSY and DONE; no queueing.
- Parity check on captured values: `err_a` = (a_par != ^a), `err_b` = (b_par != ^b), `err` = `err_a` | `err_b`.
- Result formation, registered on the BUSY→DONE edge:
  - `result` = `err` ? 0 : $signed(a)*$signed(b), full 32-bit, no truncation or saturation.
  - `result_parity` = ^`result`.
  - `arg_parity_error` = `err`.
  - `result_rdy` = 1.
- DONE: lasts one cycle; clears `result_rdy` and returns to IDLE.
- `result`, `result_parity` and `arg_parity_error` hold their values until the next result is produced or reset.
- Multiplier may be pipelined internally across the BUSY cycles; observable latency is fixed regardless of operand values or error state.

## Timing
- Reset (`rst`=1 at an edge):
  - State returns to IDLE, counter cleared.
  - `ack`, `result_rdy`, `result`, `result_parity`, `arg_parity_error` all 0 after that edge.
  - `rst` has priority over a simultaneous `req`.
- Reset mid-operation: the in-flight transaction is discarded; no `ack` or `result_rdy` is produced for it afterwards.
- Capture edge E0: `ack`=1 during cycle E0..E0+1, 0 after E0+1.
- `result_rdy`=1 during cycle E0+MULT_LATENCY..E0+MULT_LATENCY+1 (exactly one cycle). MULT_LATENCY≥2 guarantees `ack` and `result_rdy` never overlap.
- Earliest next capture edge: E0+MULT_LATENCY+1, i.e. first IDLE edge after DONE. Back-to-back throughput is one transaction per MULT_LATENCY+1 cycles.
- Initiator rule: `req` must be low by the edge after `ack` rises. If `req` is still high at the first IDLE edge after DONE, it is treated as a new request.
- Width rules:
  - Largest magnitude is -32768 × -32768 = 0x4000_0000, which fits in 32 bits.
  - Sign extension is required for negative × positive products.

## Test plan
- Reset then idle 10 cycles, `req`=0 -> every output stays 0, no `ack`/`result_rdy`.
- a=3 (par 0), b=-5/0xFFFB (par 1), MULT_LATENCY=3 -> `ack` 1 cycle after E0; `result_rdy` 3 cycles after E0 with `result`=0xFFFF_FFF1, `result_parity`=1, `arg_parity_error`=0.
- a=1 with par 0 (invalid), b=2 with par 1 (valid) -> same latency, `result`=0, `result_parity`=0, `arg_parity_error`=1. Repeat with only B invalid and with both invalid: same response.
- a=b=-32768 (0x8000, par 1 each) -> `result`=0x4000_0000, `result_parity`=1. Then a=32767, b=-32768 -> `result`=0xC000_8000.
- `req` pulsed high again during BUSY -> no second `ack`, first result unaffected. Two transactions back-to-back at the earliest legal edge -> two results, each with correct latency.
- `rst` asserted one cycle after `ack` -> no `result_rdy` for that transaction, outputs 0. Next valid request 6×7 -> `result`=42 (0x2A), `result_parity`=1.
